// File: rtl/conv_accumulator.sv
// conv_accumulator: sums KERNEL_N signed 16-bit products per window, then
// emits the full-width sum and a shifted, saturated 8-bit pixel through a
// single output register with valid/ready backpressure.
module conv_accumulator #(
  parameter int unsigned KERNEL_N = 9,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned SHIFT    = 7
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [7:0]       pix_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
  localparam int unsigned EXT_W = ACC_W - 16;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] PIX_MIN = ~PIX_MAX;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [ACC_W-1:0]         r_sum;
  logic [ACC_W-1:0]         w_sum_nxt;
  logic [7:0]               r_pix;
  logic [7:0]               w_pix_nxt;
  logic                     r_out_valid;
  logic                     w_valid_nxt;

  logic                     w_accept;
  logic                     w_xfer;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum_new;
  logic signed [ACC_W-1:0]  w_shift;
  logic [7:0]               w_pix;

  // Handshake: input is stalled only while a result is held and not taken
  assign prod_ready = ~r_out_valid | out_ready;
  assign w_accept   = prod_valid & prod_ready;
  assign w_xfer     = r_out_valid & out_ready;
  assign w_last     = (r_cnt == CNT_W'(KERNEL_N - 1));

  // Datapath: sign-extend, add, floor-shift and clamp to the 8-bit range
  assign w_prod_ext = {{EXT_W{prod_in[15]}}, prod_in};
  assign w_sum_new  = r_acc + w_prod_ext;
  assign w_shift    = w_sum_new >>> SHIFT;
  assign w_pix      = (w_shift > PIX_MAX) ? 8'h7F :
                      (w_shift < PIX_MIN) ? 8'h80 : w_shift[7:0];

  assign sum_out   = r_sum;
  assign pix_out   = r_pix;
  assign out_valid = r_out_valid;

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_pix_nxt   = r_pix;
    w_valid_nxt = r_out_valid;
    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          if (w_last) begin
            w_sum_nxt   = w_sum_new;
            w_pix_nxt   = w_pix;
            w_valid_nxt = 1'b1;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HOLD;
          end else begin
            w_acc_nxt = w_sum_new;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (w_xfer) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_ACC;
          // A product taken alongside the transfer opens the next window
          if (w_accept) begin
            w_acc_nxt = w_prod_ext;
            w_cnt_nxt = CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, counter and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_pix       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sum       <= w_sum_nxt;
      r_pix       <= w_pix_nxt;
      r_out_valid <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed scenarios plus a
// randomized run against a window-queue reference model.
module tb_conv_accumulator;

  localparam int unsigned KERNEL_N = 9;
  localparam int unsigned ACC_W    = 20;
  localparam int unsigned SHIFT    = 7;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst_n;
  logic [15:0]             prod_in;
  logic                    prod_valid;
  logic                    prod_ready;
  logic signed [ACC_W-1:0] sum_out;
  logic signed [7:0]       pix_out;
  logic                    out_valid;
  logic                    out_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int   win_q[$];
  logic m_valid;
  int   m_sum;
  int   m_pix;
  logic obs_ready;
  logic exp_ready;

  conv_accumulator #(
    .KERNEL_N(KERNEL_N),
    .ACC_W   (ACC_W),
    .SHIFT   (SHIFT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .sum_out   (sum_out),
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  // Floor division by 2^SHIFT followed by clamping to the signed 8-bit range
  function automatic int quantise(input int s);
    int d;
    int t;
    d = 1 << SHIFT;
    if (s >= 0) t = s / d;
    else        t = -((-s + d - 1) / d);
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  // One clock: apply inputs, capture ready, advance model, settle outputs
  task automatic drive(input bit pv, input int p, input bit ordy);
    logic signed [15:0] p16;
    bit accept;
    int s;
    p16 = 16'(p);
    @(negedge sys_clk);
    prod_valid = pv;
    prod_in    = p16;
    out_ready  = ordy;
    #1;
    obs_ready = prod_ready;
    exp_ready = !m_valid || ordy;
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      win_q.delete();
      m_valid = 1'b0;
      m_sum   = 0;
      m_pix   = 0;
    end else begin
      accept = pv && exp_ready;
      if (m_valid && ordy) m_valid = 1'b0;
      if (accept) begin
        win_q.push_back(int'(p16));
        if (win_q.size() == KERNEL_N) begin
          s = 0;
          foreach (win_q[i]) s += win_q[i];
          m_sum   = s;
          m_pix   = quantise(s);
          m_valid = 1'b1;
          win_q.delete();
        end
      end
    end
    #1;
  endtask

  // Drain any held result so the next scenario starts with an empty output
  task automatic flush();
    drive(1'b0, 0, 1'b1);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    drive(1'b0, 0, 1'b0);
    drive(1'b1, 123, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %0b expected 0", out_valid);
    end
    n_vec++;
    if (int'(sum_out) !== 0) begin
      n_err++; $display("FAIL reset_sum: got %0d expected 0", sum_out);
    end
    n_vec++;
    if (int'(pix_out) !== 0) begin
      n_err++; $display("FAIL reset_pix: got %0d expected 0", pix_out);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    flush();
    for (int k = 0; k < KERNEL_N; k++) begin
      drive(1'b1, 100, 1'b1);
      if (k == KERNEL_N - 2) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL b2b_early_valid: got %0b expected 0", out_valid);
        end
      end
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_valid: got %0b expected 1", out_valid);
    end
    n_vec++;
    if (int'(sum_out) !== 900) begin
      n_err++; $display("FAIL b2b_sum: got %0d expected 900", sum_out);
    end
    n_vec++;
    if (int'(pix_out) !== 7) begin
      n_err++; $display("FAIL b2b_pix: got %0d expected 7", pix_out);
    end
    drive(1'b0, 0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drop: got %0b expected 0", out_valid);
    end
    n_vec++;
    if (int'(sum_out) !== 900) begin
      n_err++; $display("FAIL b2b_sum_kept: got %0d expected 900", sum_out);
    end
  endtask

  task automatic test_saturation();
    flush();
    for (int k = 0; k < KERNEL_N; k++) drive(1'b1, -16384, 1'b1);
    n_vec++;
    if (int'(sum_out) !== -147456 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL sat_neg_sum: got %0d/%0b expected -147456/1", sum_out, out_valid);
    end
    n_vec++;
    if (int'(pix_out) !== -128) begin
      n_err++; $display("FAIL sat_neg_pix: got %0d expected -128", pix_out);
    end
    for (int k = 0; k < KERNEL_N; k++) drive(1'b1, 16384, 1'b1);
    n_vec++;
    if (int'(sum_out) !== 147456 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL sat_pos_sum: got %0d/%0b expected 147456/1", sum_out, out_valid);
    end
    n_vec++;
    if (int'(pix_out) !== 127) begin
      n_err++; $display("FAIL sat_pos_pix: got %0d expected 127", pix_out);
    end
  endtask

  task automatic test_backpressure();
    flush();
    for (int k = 0; k < KERNEL_N; k++) drive(1'b1, 10, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 7, 1'b0);
      n_vec++;
      if (out_valid !== 1'b1 || int'(sum_out) !== 90) begin
        n_err++; $display("FAIL bp_hold: got %0b/%0d expected 1/90", out_valid, sum_out);
      end
      n_vec++;
      if (obs_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_ready: got %0b expected 0", obs_ready);
      end
    end
    drive(1'b1, 5, 1'b1);
    n_vec++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got ready %0b valid %0b expected 1/0", obs_ready, out_valid);
    end
    for (int k = 1; k < KERNEL_N; k++) drive(1'b1, 5, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || int'(sum_out) !== 45) begin
      n_err++; $display("FAIL bp_next_window: got %0b/%0d expected 1/45", out_valid, sum_out);
    end
  endtask

  task automatic test_bubbles();
    flush();
    for (int i = 1; i <= KERNEL_N; i++) begin
      drive(1'b1, i, 1'b1);
      if (i < KERNEL_N) begin
        drive(1'b0, int'($urandom), 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL bub_early: got %0b expected 0", out_valid);
        end
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || int'(sum_out) !== 45 || int'(pix_out) !== 0) begin
      n_err++; $display("FAIL bub_result: got %0b/%0d/%0d expected 1/45/0", out_valid, sum_out, pix_out);
    end
  endtask

  task automatic test_reset_mid();
    flush();
    for (int k = 0; k < 5; k++) drive(1'b1, 50, 1'b1);
    sys_rst_n = 1'b0;
    drive(1'b1, 50, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || int'(sum_out) !== 0) begin
      n_err++; $display("FAIL rstmid_state: got %0b/%0d expected 0/0", out_valid, sum_out);
    end
    sys_rst_n = 1'b1;
    for (int k = 0; k < KERNEL_N; k++) begin
      drive(1'b1, 1, 1'b1);
      if (k == KERNEL_N - 2) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL rstmid_early: got %0b expected 0", out_valid);
        end
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || int'(sum_out) !== 9) begin
      n_err++; $display("FAIL rstmid_sum: got %0b/%0d expected 1/9", out_valid, sum_out);
    end
  endtask

  task automatic test_floor();
    int firsts[3];
    int pix_exp[3];
    firsts  = '{-1, 127, 128};
    pix_exp = '{-1, 0, 1};
    flush();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < KERNEL_N; k++) drive(1'b1, (k == 0) ? firsts[w] : 0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || int'(sum_out) !== firsts[w] || int'(pix_out) !== pix_exp[w]) begin
        n_err++; $display("FAIL floor_%0d: got %0b/%0d/%0d expected 1/%0d/%0d",
                          w, out_valid, sum_out, pix_out, firsts[w], pix_exp[w]);
      end
    end
  endtask

  task automatic test_random();
    flush();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 4) != 0, int'($urandom), ($urandom % 3) != 0);
      n_vec++;
      if (obs_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready@%0d: got %0b expected %0b", c, obs_ready, exp_ready);
      end
      n_vec++;
      if (out_valid !== m_valid) begin
        n_err++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, out_valid, m_valid);
      end
      n_vec++;
      if (int'(sum_out) !== m_sum || int'(pix_out) !== m_pix) begin
        n_err++; $display("FAIL rnd_data@%0d: got %0d/%0d expected %0d/%0d", c, sum_out, pix_out, m_sum, m_pix);
      end
    end
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    m_valid    = 1'b0;
    m_sum      = 0;
    m_pix      = 0;
    test_reset();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_floor();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
